// File: rtl/gyruss_timing_pkg.sv
// Shared Gyruss video timing constants, flag payload and sync window helper.
package gyruss_timing_pkg;

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned OFS_W  = 4;
  localparam int unsigned SYNC_W = 10;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_TOTAL  = 384;
  localparam int unsigned DEF_H_ACTIVE = 256;
  localparam int unsigned DEF_HS_START = 304;
  localparam int unsigned DEF_HS_LEN   = 32;
  localparam int unsigned DEF_V_TOTAL  = 264;
  localparam int unsigned DEF_VA_START = 16;
  localparam int unsigned DEF_VA_END   = 240;
  localparam int unsigned DEF_VS_START = 244;
  localparam int unsigned DEF_VS_LEN   = 8;

  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } vid_flags_t;

  // True when pos lies in [start+ofs, start+ofs+len), signed 10-bit, no wrap.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input int unsigned      start,
                                     input logic [OFS_W-1:0] ofs,
                                     input int unsigned      len);
    logic signed [SYNC_W-1:0] p;
    logic signed [SYNC_W-1:0] o;
    logic signed [SYNC_W-1:0] lo;
    logic signed [SYNC_W-1:0] hi;
    p  = signed'(SYNC_W'({1'b0, pos}));
    o  = signed'({{(SYNC_W-OFS_W){ofs[OFS_W-1]}}, ofs});
    lo = signed'(SYNC_W'(start)) + o;
    hi = lo + signed'(SYNC_W'(len));
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/gyruss_clkdiv.sv
// Generic divide-by-DIV clock enable: one-cycle registered pulse every DIV cycles.
module gyruss_clkdiv #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic en,
  output logic tick_c
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_q;

  // Edge on which the enable is generated; lets the owner advance in lockstep.
  assign tick_c = (div_q == DW'(DIV - 1));

  // Divider counts 0..DIV-1 and wraps; enable is registered from the terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      en    <= 1'b0;
    end else begin
      en    <= tick_c;
      div_q <= tick_c ? '0 : div_q + DW'(1);
    end
  end

endmodule

// File: rtl/gyruss_hvgen.sv
// Gyruss raster counters, blank/sync decode and frame-latched sync offsets.
module gyruss_hvgen
  import gyruss_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned HS_START = DEF_HS_START,
  parameter int unsigned HS_LEN   = DEF_HS_LEN,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
  parameter int unsigned VA_START = DEF_VA_START,
  parameter int unsigned VA_END   = DEF_VA_END,
  parameter int unsigned VS_START = DEF_VS_START,
  parameter int unsigned VS_LEN   = DEF_VS_LEN
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  input  logic [3:0] HOFS,
  input  logic [3:0] VOFS,
  output logic       PCLK_EN,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       FRAME
);

  logic             tick_c;
  logic [CNT_W-1:0] ph_n;
  logic [CNT_W-1:0] pv_n;
  logic [OFS_W-1:0] hofs_q;
  logic [OFS_W-1:0] vofs_q;
  logic [OFS_W-1:0] hofs_n;
  logic [OFS_W-1:0] vofs_n;
  logic             frame_step;
  vid_flags_t       flags_n;

  gyruss_clkdiv #(.DIV(CLK_DIV)) u_clkdiv (
    .clk    (MCLK),
    .rst_n  (RESET_N),
    .en     (PCLK_EN),
    .tick_c (tick_c)
  );

  // Next raster position, offset latch at frame start, and decode of the next position.
  always_comb begin
    ph_n       = PH;
    pv_n       = PV;
    hofs_n     = hofs_q;
    vofs_n     = vofs_q;
    frame_step = 1'b0;
    if (tick_c) begin
      if (PH == CNT_W'(H_TOTAL - 1)) begin
        ph_n = '0;
        if (PV == CNT_W'(V_TOTAL - 1)) begin
          pv_n       = '0;
          frame_step = 1'b1;
        end else begin
          pv_n = PV + CNT_W'(1);
        end
      end else begin
        ph_n = PH + CNT_W'(1);
      end
    end
    if (frame_step) begin
      hofs_n = HOFS;
      vofs_n = VOFS;
    end
    flags_n.hblank = (ph_n >= CNT_W'(H_ACTIVE));
    flags_n.vblank = (pv_n < CNT_W'(VA_START)) || (pv_n >= CNT_W'(VA_END));
    flags_n.hsync  = in_window(ph_n, HS_START, hofs_n, HS_LEN);
    flags_n.vsync  = in_window(pv_n, VS_START, vofs_n, VS_LEN);
  end

  // Counter, offset and decoded-output registers; decode only moves on pixel edges.
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      PH     <= '0;
      PV     <= '0;
      hofs_q <= '0;
      vofs_q <= '0;
      HBLANK <= 1'b0;
      VBLANK <= 1'b1;
      HSYNC  <= 1'b0;
      VSYNC  <= 1'b0;
      FRAME  <= 1'b0;
    end else begin
      PH     <= ph_n;
      PV     <= pv_n;
      hofs_q <= hofs_n;
      vofs_q <= vofs_n;
      FRAME  <= frame_step;
      if (tick_c) begin
        HBLANK <= flags_n.hblank;
        VBLANK <= flags_n.vblank;
        HSYNC  <= flags_n.hsync;
        VSYNC  <= flags_n.vsync;
      end
    end
  end

endmodule

// File: tb/tb_gyruss_hvgen.sv
// Scoreboard bench for gyruss_hvgen on a reduced raster (short frames keep runtime low).
// Geometry: 64x40, active 40 px / lines 4..27, HSYNC 48+ofs len 6, VSYNC 30+ofs len 2.
module tb_gyruss_hvgen;

  localparam int DIV = 4;
  localparam int H   = 64;
  localparam int HA  = 40;
  localparam int HS  = 48;
  localparam int HL  = 6;
  localparam int V   = 40;
  localparam int VAS = 4;
  localparam int VAE = 28;
  localparam int VS  = 30;
  localparam int VL  = 2;
  localparam int FR  = H * V;

  typedef struct packed {
    logic [8:0] ph;
    logic [8:0] pv;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       fr;
  } obs_t;

  localparam obs_t RESET_OBS = '{ph: 9'd0, pv: 9'd0, hb: 1'b0, vb: 1'b1,
                                 hs: 1'b0, vs: 1'b0, fr: 1'b0};

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] hofs = 4'd0;
  logic [3:0] vofs = 4'd0;
  logic       pclk_en;
  logic [8:0] ph;
  logic [8:0] pv;
  logic       hblank, vblank, hsync, vsync, frame;

  int errors = 0;
  int checks = 0;

  obs_t q[$];
  int   n = 0;
  int   cur_hofs = 0;
  int   cur_vofs = 0;
  int   gap = 0;

  int   pix_cnt = 0;
  obs_t last;
  int   line_first, line_last;
  int   vs_cur_first, vs_cur_last;
  int   vs_done_first = -1;
  int   vs_done_last = -1;
  int   hs_first[V];
  int   hs_last[V];

  gyruss_hvgen #(
    .CLK_DIV(DIV), .H_TOTAL(H), .H_ACTIVE(HA), .HS_START(HS), .HS_LEN(HL),
    .V_TOTAL(V), .VA_START(VAS), .VA_END(VAE), .VS_START(VS), .VS_LEN(VL)
  ) dut (
    .MCLK(mclk), .RESET_N(rst_n), .HOFS(hofs), .VOFS(vofs),
    .PCLK_EN(pclk_en), .PH(ph), .PV(pv), .HBLANK(hblank), .VBLANK(vblank),
    .HSYNC(hsync), .VSYNC(vsync), .FRAME(frame)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got ph=%0d pv=%0d hb/vb/hs/vs/fr=%b%b%b%b%b expected ph=%0d pv=%0d hb/vb/hs/vs/fr=%b%b%b%b%b (t=%0t)",
               name, act.ph, act.pv, act.hb, act.vb, act.hs, act.vs, act.fr,
               exp.ph, exp.pv, exp.hb, exp.vb, exp.hs, exp.vs, exp.fr, $time);
    end
  endtask

  // Expected outputs for pixel index k counted from reset release.
  function automatic obs_t model(input int k);
    obs_t e;
    int   x, y;
    x = k % H;
    y = (k / H) % V;
    e.fr = ((k % FR) == 0);
    if (e.fr) begin
      cur_hofs = int'($signed(hofs));
      cur_vofs = int'($signed(vofs));
    end
    e.ph = 9'(x);
    e.pv = 9'(y);
    e.hb = (x >= HA);
    e.vb = (y < VAS) || (y >= VAE);
    e.hs = (x >= HS + cur_hofs) && (x < HS + cur_hofs + HL);
    e.vs = (y >= VS + cur_vofs) && (y < VS + cur_vofs + VL);
    return e;
  endfunction

  // Push the next pixel's expectation and wait (bounded) for the monitor to consume it.
  task automatic step();
    n++;
    q.push_back(model(n));
    for (int i = 0; i < 3 * DIV && q.size() != 0; i++) begin
      @(negedge mclk);
      #1;
    end
    if (q.size() != 0) begin
      chk("pclk_timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  // MCLK gap since the previous enable (or since reset release).
  always @(posedge mclk) begin
    if (!rst_n) gap <= 0;
    else        gap <= pclk_en ? 1 : gap + 1;
  end

  // Monitor: pops the scoreboard on each PCLK_EN and checks hold, range and framing.
  always @(negedge mclk) begin
    obs_t cur;
    cur = '{ph: ph, pv: pv, hb: hblank, vb: vblank, hs: hsync, vs: vsync, fr: frame};
    if (!rst_n) begin
      pix_cnt      = 0;
      last         = RESET_OBS;
      line_first   = -1;
      line_last    = -1;
      vs_cur_first = -1;
      vs_cur_last  = -1;
    end else begin
      chk("ph_range", (int'(ph) < H) ? 1 : 0, 1);
      chk("pv_range", (int'(pv) < V) ? 1 : 0, 1);
      chk("frame_with_pclk", (frame && !pclk_en) ? 1 : 0, 0);
      if (pclk_en) begin
        pix_cnt++;
        chk("pclk_gap", gap, DIV);
        if (q.size() == 0) begin
          chk("unexpected_pclk", 1, 0);
        end else begin
          chk_obs("pixel", cur, q.pop_front());
        end
        if (frame) begin
          chk("frame_spacing", pix_cnt, FR);
          pix_cnt       = 0;
          vs_done_first = vs_cur_first;
          vs_done_last  = vs_cur_last;
          vs_cur_first  = -1;
          vs_cur_last   = -1;
        end
        if (ph == 9'd0) begin
          line_first = -1;
          line_last  = -1;
          if (vsync) begin
            if (vs_cur_first < 0) vs_cur_first = int'(pv);
            vs_cur_last = int'(pv);
          end
        end
        if (hsync) begin
          if (line_first < 0) line_first = int'(ph);
          line_last = int'(ph);
        end
        if (int'(ph) == H - 1 && int'(pv) < V) begin
          hs_first[int'(pv)] = line_first;
          hs_last[int'(pv)]  = line_last;
        end
        last    = cur;
        last.fr = 1'b0;
      end else begin
        chk_obs("hold_between_pclk", cur, last);
      end
    end
  end

  initial begin
    for (int i = 0; i < V; i++) begin
      hs_first[i] = -1;
      hs_last[i]  = -1;
    end
    repeat (3) @(negedge mclk);
    #1 rst_n = 1'b1;

    // Frame 0, zero offsets; program +7/-8 mid-frame for the next frame.
    run_to(100);
    hofs = 4'd7;
    vofs = 4'b1000;
    run_to(FR);
    chk("f0_hs_first", hs_first[10], 48);
    chk("f0_hs_last",  hs_last[10],  53);
    chk("f0_vs_first", vs_done_first, 30);
    chk("f0_vs_last",  vs_done_last,  31);

    // Frame 1 uses +7/-8; restore zero for frame 2.
    run_to(FR + 200);
    hofs = 4'd0;
    vofs = 4'd0;
    run_to(2 * FR);
    chk("f1_hs_first", hs_first[10], 55);
    chk("f1_hs_last",  hs_last[10],  60);
    chk("f1_vs_first", vs_done_first, 22);
    chk("f1_vs_last",  vs_done_last,  23);

    // Frame 2: HOFS -> -3 at line 20 must not affect the rest of this frame.
    run_to(2 * FR + 20 * H);
    hofs = 4'b1101;
    run_to(3 * FR);
    chk("f2_hs_first_l30", hs_first[30], 48);
    chk("f2_hs_last_l30",  hs_last[30],  53);
    chk("f2_vs_first", vs_done_first, 30);
    chk("f2_vs_last",  vs_done_last,  31);

    // Frame 3 picks up -3 from its first edge.
    run_to(3 * FR + 20 * H + 30);
    chk("f3_hs_first_l5", hs_first[5], 45);
    chk("f3_hs_last_l5",  hs_last[5],  50);

    // One-cycle reset at PH=30, PV=20.
    rst_n = 1'b0;
    @(posedge mclk);
    #1;
    chk("rst_ph",     int'(ph), 0);
    chk("rst_pv",     int'(pv), 0);
    chk("rst_pclk",   int'(pclk_en), 0);
    chk("rst_hblank", int'(hblank), 0);
    chk("rst_vblank", int'(vblank), 1);
    chk("rst_hsync",  int'(hsync), 0);
    chk("rst_vsync",  int'(vsync), 0);
    chk("rst_frame",  int'(frame), 0);
    @(negedge mclk);
    #1 rst_n = 1'b1;
    n        = 0;
    cur_hofs = 0;
    cur_vofs = 0;
    q.delete();

    // Latched offset cleared by reset even though HOFS pins still read -3.
    run_to(11 * H);
    chk("postrst_hs_first", hs_first[10], 48);
    chk("postrst_hs_last",  hs_last[10],  53);
    run_to(FR + 11 * H);
    chk("postrst_f1_hs_first", hs_first[10], 45);
    chk("postrst_f1_hs_last",  hs_last[10],  50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
